// File: rtl/eop_detect_filt.sv
// USB receive-path End-Of-Packet qualifier: synchronises D+/D-, samples on the bit strobe,
// and reports valid EOP, bad EOP termination, qualified SE0 and bus reset.
module eop_detect_filt #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SE0_MIN     = 2,
    parameter int unsigned RESET_BITS  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic shift_enable,
    output logic eop,
    output logic eop_err,
    output logic in_eop,
    output logic bus_reset
);

    localparam int unsigned CNT_W = $clog2(RESET_BITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SE0_CNT = 2'd1,
        SE0_OK  = 2'd2,
        BUS_RST = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] dp_sync_q, dp_sync_d;
    logic [SYNC_STAGES-1:0] dm_sync_q, dm_sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   eop_q, eop_d;
    logic                   eop_err_q, eop_err_d;
    logic                   in_eop_q, in_eop_d;
    logic                   bus_reset_q, bus_reset_d;
    logic                   dp, dm, line_se0, line_j;

    // Line synchronisers run every clock; reset loads idle J
    always_comb begin
        dp_sync_d = {dp_sync_q[SYNC_STAGES-2:0], d_plus};
        dm_sync_d = {dm_sync_q[SYNC_STAGES-2:0], d_minus};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_sync_q <= '1;
            dm_sync_q <= '0;
        end else begin
            dp_sync_q <= dp_sync_d;
            dm_sync_q <= dm_sync_d;
        end
    end

    assign dp       = dp_sync_q[SYNC_STAGES-1];
    assign dm       = dm_sync_q[SYNC_STAGES-1];
    assign line_se0 = !dp && !dm;
    assign line_j   = dp && !dm;
    assign cnt_inc  = (cnt_q == CNT_W'(RESET_BITS)) ? cnt_q : cnt_q + CNT_W'(1);

    // State register, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            eop_q       <= 1'b0;
            eop_err_q   <= 1'b0;
            in_eop_q    <= 1'b0;
            bus_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            eop_q       <= eop_d;
            eop_err_q   <= eop_err_d;
            in_eop_q    <= in_eop_d;
            bus_reset_q <= bus_reset_d;
        end
    end

    // Next state: advances only on bit-sample cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (shift_enable) begin
            case (state_q)
                IDLE: begin
                    if (line_se0) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (SE0_MIN == 1) ? SE0_OK : SE0_CNT;
                    end else begin
                        cnt_d = '0;
                    end
                end
                SE0_CNT: begin
                    if (line_se0) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(SE0_MIN)) state_d = SE0_OK;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                SE0_OK: begin
                    if (line_se0) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(RESET_BITS)) state_d = BUS_RST;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                BUS_RST: begin
                    if (line_se0) begin
                        cnt_d = cnt_inc;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode; pulses only leave SE0_OK on a terminating sample
    always_comb begin
        eop_d       = 1'b0;
        eop_err_d   = 1'b0;
        in_eop_d    = (state_d == SE0_OK);
        bus_reset_d = (state_d == BUS_RST);
        if (shift_enable && (state_q == SE0_OK) && !line_se0) begin
            eop_d     = line_j;
            eop_err_d = !line_j;
        end
    end

    assign eop       = eop_q;
    assign eop_err   = eop_err_q;
    assign in_eop    = in_eop_q;
    assign bus_reset = bus_reset_q;

endmodule
